// File: rtl/present80_round_ctrl.sv
// Iterative PRESENT-80 encryptor: one sbox/permutation round per clock, with
// valid/ready handshakes on the request and the ciphertext sides.

module present80_sbox (
    input  logic [3:0] x,
    output logic [3:0] y
);
    always_comb begin
        y = 4'h0;
        case (x)
            4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
            4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
            4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
            4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  4'hF: y = 4'h2;
            default: y = 4'h0;
        endcase
    end
endmodule

module present80_perm (
    input  logic [63:0] din,
    output logic [63:0] dout
);
    // Bit i moves to (16*i) mod 63; bit 63 stays put.
    for (genvar i = 0; i < 63; i++) begin : g_bit
        assign dout[(16*i)%63] = din[i];
    end
    assign dout[63] = din[63];
endmodule

module present80_round_ctrl #(
    parameter int NUM_ROUNDS = 31,
    parameter int RCNT_W     = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    output logic              ready_o,
    input  logic [63:0]       plaintext_i,
    input  logic [79:0]       key_i,
    output logic [63:0]       data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              busy_o,
    output logic [RCNT_W-1:0] round_o
);
    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_t;

    fsm_t              fsm, fsm_nxt;
    logic [63:0]       state_q;
    logic [79:0]       key_q;
    logic [RCNT_W-1:0] round_q;
    logic [63:0]       data_q;
    logic              valid_q;

    logic [63:0] rk, sb_in, sb_out, perm_out;
    logic [79:0] key_rot, key_nxt;
    logic [3:0]  key_sb;
    logic [4:0]  rc5;
    logic        last;

    assign rk    = key_q[79:16];
    assign sb_in = state_q ^ rk;
    assign last  = (round_q == RCNT_W'(NUM_ROUNDS));
    assign rc5   = 5'(round_q);

    for (genvar n = 0; n < 16; n++) begin : g_sbox
        present80_sbox u_sbox (.x(sb_in[4*n +: 4]), .y(sb_out[4*n +: 4]));
    end

    present80_perm u_perm (.din(sb_out), .dout(perm_out));

    // Key schedule: rotate left 61, sbox the top nibble, fold the round count in.
    assign key_rot = {key_q[18:0], key_q[79:19]};
    present80_sbox u_ksbox (.x(key_rot[79:76]), .y(key_sb));
    assign key_nxt = {key_sb, key_rot[75:20], key_rot[19:15] ^ rc5, key_rot[14:0]};

    always_ff @(posedge clk_i) begin
        if (rst_i) fsm <= IDLE;
        else       fsm <= fsm_nxt;
    end

    always_comb begin
        fsm_nxt = fsm;
        case (fsm)
            IDLE:    if (start_i) fsm_nxt = ROUND;
            ROUND:   if (last)    fsm_nxt = FINAL;
            FINAL:                fsm_nxt = DONE;
            DONE:    if (ready_i) fsm_nxt = IDLE;
            default:              fsm_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= '0;
            key_q   <= '0;
            round_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            case (fsm)
                IDLE: if (start_i) begin
                    state_q <= plaintext_i;
                    key_q   <= key_i;
                    round_q <= RCNT_W'(1);
                end
                ROUND: begin
                    state_q <= perm_out;
                    key_q   <= key_nxt;
                    if (!last) round_q <= round_q + RCNT_W'(1);
                end
                FINAL: begin
                    data_q  <= state_q ^ rk;
                    valid_q <= 1'b1;
                end
                DONE: if (ready_i) begin
                    valid_q <= 1'b0;
                    round_q <= '0;
                end
                default: ;
            endcase
        end
    end

    assign ready_o = (fsm == IDLE);
    assign busy_o  = (fsm == ROUND) || (fsm == FINAL);
    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign round_o = round_q;
endmodule

// File: tb/tb_present80_round_ctrl.sv
// Scoreboard bench for present80_round_ctrl: driver pushes reference ciphertexts,
// a negedge monitor pops and compares on every output handshake.

module tb_present80_round_ctrl;
    localparam int NR = 31;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic        ready_o;
    logic [63:0] plaintext_i = '0;
    logic [79:0] key_i = '0;
    logic [63:0] data_o;
    logic        valid_o;
    logic        ready_i = 1'b1;
    logic        busy_o;
    logic [4:0]  round_o;

    present80_round_ctrl dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .ready_o(ready_o),
        .plaintext_i(plaintext_i), .key_i(key_i), .data_o(data_o),
        .valid_o(valid_o), .ready_i(ready_i), .busy_o(busy_o), .round_o(round_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [63:0] sb[$];
    int          acc_q[$];

    localparam logic [3:0] SBOX [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                         4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference cipher straight from the algorithm description.
    function automatic logic [63:0] ref_enc(input logic [63:0] pt, input logic [79:0] k);
        logic [63:0] s, t;
        logic [79:0] kk;
        s  = pt;
        kk = k;
        for (int r = 1; r <= NR; r++) begin
            s = s ^ kk[79:16];
            for (int n = 0; n < 16; n++) t[4*n +: 4] = SBOX[s[4*n +: 4]];
            for (int i = 0; i < 64; i++) s[(i == 63) ? 63 : (16*i) % 63] = t[i];
            kk = {kk[18:0], kk[79:19]};
            kk[79:76] = SBOX[kk[79:76]];
            kk[19:15] = kk[19:15] ^ 5'(r);
        end
        return s ^ kk[79:16];
    endfunction

    // Monitor
    logic [63:0] prev_data = '0;
    logic        prev_valid = 1'b0;
    logic        prev_hs = 1'b0;
    always @(negedge clk) begin
        if (!rst_i) begin
            if (valid_o && !prev_valid) begin
                if (acc_q.size() == 0) chk("unexpected_valid", 80'(valid_o), 80'(0));
                else chk("latency", 80'(cyc - acc_q[0]), 80'(NR + 1));
            end
            if (prev_valid && !prev_hs) begin
                chk("hold_valid", 80'(valid_o), 80'(1));
                chk("hold_data", 80'(data_o), 80'(prev_data));
            end
            if (valid_o && ready_i) begin
                if (sb.size() == 0) chk("output_without_request", 80'(1), 80'(0));
                else begin
                    chk("ciphertext", 80'(data_o), 80'(sb.pop_front()));
                    if (acc_q.size() != 0) void'(acc_q.pop_front());
                end
            end
        end
        prev_valid = valid_o && !rst_i;
        prev_hs    = valid_o && ready_i;
        prev_data  = data_o;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] pt, input logic [79:0] k, input logic [63:0] exp);
        int n;
        n = 0;
        tick();
        while (!ready_o && n < 200) begin tick(); n++; end
        if (!ready_o) begin chk("accept_timeout", 80'(0), 80'(1)); return; end
        start_i = 1'b1; plaintext_i = pt; key_i = k;
        tick();
        sb.push_back(exp);
        acc_q.push_back(cyc);
        start_i = 1'b0;
        plaintext_i = {$urandom, $urandom};
        key_i = {16'($urandom), $urandom, $urandom};
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 400) begin tick(); n++; end
        chk("drain", 80'(sb.size()), 80'(0));
    endtask

    logic [63:0] rpt;
    logic [79:0] rkey;
    bit          rand_done;
    int          last_acc, gap0;

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        rst_i = 1'b1;
        tick(); tick();
        @(negedge clk);
        chk("rst_ready", 80'(ready_o), 80'(1));
        chk("rst_valid", 80'(valid_o), 80'(0));
        chk("rst_busy", 80'(busy_o), 80'(0));
        chk("rst_data", 80'(data_o), 80'(0));
        chk("rst_round", 80'(round_o), 80'(0));
        tick();
        rst_i = 1'b0;

        // Known-answer vectors
        ready_i = 1'b1;
        send(64'h0, 80'h0, 64'h5579C1387B228445);
        send(64'h0, {80{1'b1}}, 64'hE72C46C0F5945049);
        send({64{1'b1}}, 80'h0, 64'hA112FFC72F68417B);
        send({64{1'b1}}, {80{1'b1}}, 64'h3333DCD3213210D2);
        drain();

        // Backpressure: output holds, starts ignored, release returns to IDLE
        ready_i = 1'b0;
        rpt = {$urandom, $urandom}; rkey = {16'($urandom), $urandom, $urandom};
        send(rpt, rkey, ref_enc(rpt, rkey));
        for (int n = 0; n < 100 && !valid_o; n++) tick();
        chk("bp_valid_rise", 80'(valid_o), 80'(1));
        for (int n = 0; n < 10; n++) begin
            start_i = 1'($urandom);
            plaintext_i = {$urandom, $urandom};
            tick();
            chk("bp_ready_low", 80'(ready_o), 80'(0));
            chk("bp_busy_low", 80'(busy_o), 80'(0));
        end
        start_i = 1'b0;
        ready_i = 1'b1;
        tick();
        chk("bp_ready_back", 80'(ready_o), 80'(1));
        chk("bp_valid_drop", 80'(valid_o), 80'(0));
        chk("bp_round_clr", 80'(round_o), 80'(0));
        drain();

        // Start/new inputs during round 7 must not disturb the block
        rpt = {$urandom, $urandom}; rkey = {16'($urandom), $urandom, $urandom};
        send(rpt, rkey, ref_enc(rpt, rkey));
        for (int k = 1; k <= NR; k++) begin
            chk("round_seq", 80'(round_o), 80'(k));
            chk("busy_round", 80'(busy_o), 80'(1));
            if (k == 7) begin
                start_i = 1'b1;
                plaintext_i = {$urandom, $urandom};
                key_i = {16'($urandom), $urandom, $urandom};
            end else start_i = 1'b0;
            tick();
        end
        start_i = 1'b0;
        chk("busy_final", 80'(busy_o), 80'(1));
        chk("round_final", 80'(round_o), 80'(NR));
        chk("valid_final", 80'(valid_o), 80'(0));
        drain();

        // Reset at round 15 aborts the block
        rpt = {$urandom, $urandom}; rkey = {16'($urandom), $urandom, $urandom};
        send(rpt, rkey, ref_enc(rpt, rkey));
        for (int n = 0; n < 14; n++) tick();
        chk("round15", 80'(round_o), 80'(15));
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        sb.delete();
        acc_q.delete();
        chk("mid_rst_ready", 80'(ready_o), 80'(1));
        chk("mid_rst_valid", 80'(valid_o), 80'(0));
        chk("mid_rst_round", 80'(round_o), 80'(0));
        chk("mid_rst_data", 80'(data_o), 80'(0));
        chk("mid_rst_busy", 80'(busy_o), 80'(0));
        rpt = {$urandom, $urandom}; rkey = {16'($urandom), $urandom, $urandom};
        send(rpt, rkey, ref_enc(rpt, rkey));
        drain();

        // Random traffic with random backpressure
        rand_done = 1'b0;
        fork
            begin
                for (int b = 0; b < 12; b++) begin
                    logic [63:0] p;
                    logic [79:0] k;
                    p = {$urandom, $urandom};
                    k = {16'($urandom), $urandom, $urandom};
                    send(p, k, ref_enc(p, k));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    tick();
                    ready_i = 1'($urandom);
                end
            end
        join
        ready_i = 1'b1;
        drain();

        // Back-to-back with start and ready tied high
        start_i = 1'b1;
        last_acc = 0;
        gap0 = 0;
        for (int b = 0; b < 5; b++) begin
            int n;
            n = 0;
            while (!ready_o && n < 200) begin tick(); n++; end
            chk("b2b_accept", 80'(ready_o), 80'(1));
            plaintext_i = {$urandom, $urandom};
            key_i = {16'($urandom), $urandom, $urandom};
            sb.push_back(ref_enc(plaintext_i, key_i));
            tick();
            acc_q.push_back(cyc);
            if (b == 1) gap0 = cyc - last_acc;
            if (b > 1) chk("b2b_spacing", 80'(cyc - last_acc), 80'(gap0));
            last_acc = cyc;
            for (int k = 1; k <= NR; k++) begin
                chk("b2b_round", 80'(round_o), 80'(k));
                tick();
            end
        end
        start_i = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
